// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
// Holds the scan-state enumeration, the all-off output constants and a
// helper that turns a scan state into its active-low digit enable.
package seven_seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    SCAN0 = 2'd0,
    SCAN1 = 2'd1,
    SCAN2 = 2'd2,
    SCAN3 = 2'd3
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Active-low one-hot enable for the digit addressed by a scan state.
  function automatic logic [3:0] dig_enable(input scan_state_e s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle of the control inputs and display/count outputs of the scan
// controller.
//   inc/clr/hold/lzb : count and display controls (driven by master)
//   seg[7:0]         : active-low segments, dp on [7]
//   dig[3:0]         : active-low digit enables
//   count[15:0]      : 4-digit BCD count, digit 0 on [3:0]
//   wrap             : one-cycle 9999->0000 rollover pulse
interface seven_seg_scan_ctrl_if;
  logic        inc;
  logic        clr;
  logic        hold;
  logic        lzb;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic [15:0] count;
  logic        wrap;

  modport master (output inc, clr, hold, lzb, input seg, dig, count, wrap);
  modport slave  (input inc, clr, hold, lzb, output seg, dig, count, wrap);
endinterface

// File: rtl/seven_seg_scan_ctrl_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
//   digit[3:0] : BCD value 0..9 (other codes decode to all-off)
//   blank      : forces all segments off
//   seg_n[6:0] : segments g..a on [6:0], 0 = lit
module bcd_to_seg (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    if (!blank) begin
      case (digit)
        4'd0:    seg_n = 7'h40;
        4'd1:    seg_n = 7'h79;
        4'd2:    seg_n = 7'h24;
        4'd3:    seg_n = 7'h30;
        4'd4:    seg_n = 7'h19;
        4'd5:    seg_n = 7'h12;
        4'd6:    seg_n = 7'h02;
        4'd7:    seg_n = 7'h78;
        4'd8:    seg_n = 7'h00;
        4'd9:    seg_n = 7'h10;
        default: seg_n = 7'h7F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit BCD counter with a multiplexed, ghost-suppressed seven-segment
// scan driver.
//   clk, rst : system clock (rising edge), asynchronous active-high reset
//   bus      : slave side of seven_seg_scan_ctrl_if (controls in,
//              seg/dig/count/wrap out, all registered)
// Parameters: REFRESH_DIV cycles per digit slot, BLANK_CYC all-off cycles
// at the start of each slot (BLANK_CYC < REFRESH_DIV, REFRESH_DIV >= 4).
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input logic                 clk,
  input logic                 rst,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

  logic [PW-1:0] presc_q, presc_d;
  scan_state_e   state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;

  logic          accept_inc;
  logic [3:0]    digit_zero;
  logic [3:0]    digit_blank;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [6:0]    seg7;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_zero
      assign digit_zero[gi] = (count_q[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  // Counter: clr beats hold beats inc; carry ripples through digits at 9.
  always_comb begin
    logic carry;
    accept_inc = bus.inc & ~bus.clr & ~bus.hold;
    wrap_d     = accept_inc && (count_q == 16'h9999);
    count_d    = count_q;
    carry      = accept_inc;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[i*4 +: 4] >= 4'd9) begin
          count_d[i*4 +: 4] = 4'd0;
        end else begin
          count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (bus.clr) count_d = 16'h0000;
  end

  // Prescaler and scan state advance only with time, never with the count.
  always_comb begin
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      state_d = scan_state_e'(state_q + 2'd1);
    end else begin
      presc_d = presc_q + PW'(1);
      state_d = state_q;
    end
  end

  // Leading-zero blanking: a digit blanks only if every higher digit does.
  always_comb begin
    digit_blank[3] = bus.lzb & digit_zero[3];
    digit_blank[2] = digit_blank[3] & digit_zero[2];
    digit_blank[1] = digit_blank[2] & digit_zero[1];
    digit_blank[0] = 1'b0;
  end

  always_comb begin
    case (state_d)
      SCAN0:   begin cur_digit = count_q[3:0];   cur_blank = digit_blank[0]; end
      SCAN1:   begin cur_digit = count_q[7:4];   cur_blank = digit_blank[1]; end
      SCAN2:   begin cur_digit = count_q[11:8];  cur_blank = digit_blank[2]; end
      default: begin cur_digit = count_q[15:12]; cur_blank = digit_blank[3]; end
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg_n (seg7)
  );

  // Outputs are computed from next-state prescaler/state so that the
  // registered dig/seg line up with the prescaler value they belong to.
  always_comb begin
    if (presc_d < BLANK_END) begin
      dig_d = DIG_OFF;
      seg_d = SEG_OFF;
    end else begin
      dig_d = dig_enable(state_d);
      seg_d = {1'b1, seg7};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      state_q <= SCAN0;
      count_q <= 16'h0000;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dig   = dig_q;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  seven_seg_scan_ctrl_if bus ();

  seven_seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [3:0] exp_dig(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return 4'b1111 ^ (one << s);
  endfunction

  // Advance until the given slot is in its visible phase (bounded).
  task automatic wait_visible(input int slot);
    int n;
    n = 0;
    while (!(((cyc % RD) >= BC) && (((cyc / RD) % 4) == slot)) && n < 64) begin
      tick();
      n++;
    end
    check($sformatf("reach_slot%0d", slot), 16'(n < 64), 16'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.inc  = 1'b0;
    bus.clr  = 1'b0;
    bus.hold = 1'b0;
    bus.lzb  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dig", 16'(bus.dig), 16'hF);
    check("rst_seg", 16'(bus.seg), 16'hFF);
    check("rst_count", bus.count, 16'h0000);
    check("rst_wrap", 16'(bus.wrap), 16'h0);
    rst = 1'b0;
    cyc = 0;

    // Idle scan: 2 blank, 6 showing "0" on digit 0, 2 blank, 6 on digit 1
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      if ((cyc % RD) < BC) begin
        check($sformatf("idle_dig_c%0d", k), 16'(bus.dig), 16'hF);
        check($sformatf("idle_seg_c%0d", k), 16'(bus.seg), 16'hFF);
      end else begin
        check($sformatf("idle_dig_c%0d", k), 16'(bus.dig), 16'(exp_dig((cyc / RD) % 4)));
        check($sformatf("idle_seg_c%0d", k), 16'(bus.seg), 16'hC0);
      end
    end

    // 12 single-cycle inc pulses
    for (int i = 0; i < 12; i++) begin
      bus.inc = 1'b1;
      tick();
      bus.inc = 1'b0;
      tick();
    end
    check("inc12_count", bus.count, 16'h0012);
    wait_visible(1);
    check("inc12_s1_dig", 16'(bus.dig), 16'hD);
    check("inc12_s1_seg", 16'(bus.seg), 16'hF9);
    wait_visible(0);
    check("inc12_s0_dig", 16'(bus.dig), 16'hE);
    check("inc12_s0_seg", 16'(bus.seg), 16'hA4);

    // Clear, preload to 9999, then roll over
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_count", bus.count, 16'h0000);
    bus.inc = 1'b1;
    repeat (9999) tick();
    check("pre_count", bus.count, 16'h9999);
    check("pre_wrap", 16'(bus.wrap), 16'h0);
    tick();
    check("roll_count", bus.count, 16'h0000);
    check("roll_wrap", 16'(bus.wrap), 16'h1);
    bus.inc = 1'b0;
    tick();
    check("post_wrap", 16'(bus.wrap), 16'h0);
    check("post_count", bus.count, 16'h0000);

    // Priority: hold blocks inc, clr beats everything
    bus.inc = 1'b1;
    repeat (3) tick();
    bus.inc = 1'b0;
    check("three_count", bus.count, 16'h0003);
    bus.inc  = 1'b1;
    bus.hold = 1'b1;
    tick();
    check("hold_count", bus.count, 16'h0003);
    check("hold_wrap", 16'(bus.wrap), 16'h0);
    bus.clr = 1'b1;
    tick();
    check("all3_count", bus.count, 16'h0000);
    check("all3_wrap", 16'(bus.wrap), 16'h0);
    bus.inc  = 1'b0;
    bus.hold = 1'b0;
    bus.clr  = 1'b0;

    // Leading-zero blanking at 0105
    bus.inc = 1'b1;
    repeat (105) tick();
    bus.inc = 1'b0;
    check("lz_count", bus.count, 16'h0105);
    bus.lzb = 1'b1;
    tick();
    wait_visible(3);
    check("lz_s3_dig", 16'(bus.dig), 16'h7);
    check("lz_s3_seg", 16'(bus.seg), 16'hFF);
    wait_visible(2);
    check("lz_s2_dig", 16'(bus.dig), 16'hB);
    check("lz_s2_seg", 16'(bus.seg), 16'hF9);
    wait_visible(1);
    check("lz_s1_dig", 16'(bus.dig), 16'hD);
    check("lz_s1_seg", 16'(bus.seg), 16'hC0);
    wait_visible(0);
    check("lz_s0_dig", 16'(bus.dig), 16'hE);
    check("lz_s0_seg", 16'(bus.seg), 16'h92);
    bus.lzb = 1'b0;
    tick();
    wait_visible(3);
    check("nolz_s3_seg", 16'(bus.seg), 16'hC0);

    // Asynchronous reset in the middle of SCAN2
    wait_visible(2);
    check("mid_s2_dig", 16'(bus.dig), 16'hB);
    rst = 1'b1;
    #1;
    check("arst_dig", 16'(bus.dig), 16'hF);
    check("arst_seg", 16'(bus.seg), 16'hFF);
    check("arst_count", bus.count, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check("rel_dig_c0", 16'(bus.dig), 16'hF);
    tick();
    check("rel_dig_c1", 16'(bus.dig), 16'hF);
    tick();
    check("rel_dig_c2", 16'(bus.dig), 16'hE);
    check("rel_seg_c2", 16'(bus.seg), 16'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
